// File: rtl/symbols_pkg.sv
// Shared types for the symbol counter/emitter blocks: FSM states, count widths, saturating add.
// No logic of its own, so no latency or backpressure.
// The emitted-symbol total saturates rather than wrapping.
package symbols_pkg;

    localparam int CNT_W   = 8;
    localparam int TOTAL_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } emit_state_t;

    function automatic logic [TOTAL_W-1:0] sat_inc(input logic [TOTAL_W-1:0] v);
        return (&v) ? v : v + TOTAL_W'(1);
    endfunction

endpackage

// File: rtl/symbol_table.sv
// Alphabet/count table: one registered write port and one combinational indexed read port.
// A write shows on the read port one cycle later; the read port has no latency.
// No backpressure; writes to an index outside the table are dropped.
module symbol_table
    import symbols_pkg::*;
#(
    parameter int S_WIDTH   = 8,
    parameter int N_SYMBOLS = 8,
    localparam int AW       = $clog2(N_SYMBOLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [S_WIDTH-1:0] wr_symbol,
    input  logic [CNT_W-1:0]   wr_count,
    input  logic [AW-1:0]      rd_addr,
    output logic [S_WIDTH-1:0] rd_symbol,
    output logic [CNT_W-1:0]   rd_count
);

    logic [S_WIDTH-1:0] sym_q [N_SYMBOLS];
    logic [CNT_W-1:0]   cnt_q [N_SYMBOLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYMBOLS; i++) begin
                sym_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < N_SYMBOLS)) begin
            sym_q[wr_addr] <= wr_symbol;
            cnt_q[wr_addr] <= wr_count;
        end
    end

    assign rd_symbol = sym_q[rd_addr];
    assign rd_count  = cnt_q[rd_addr];

endmodule

// File: rtl/symbol_emitter.sv
// Emits symbol[i] count[i] times for each table entry i, in ascending index order.
// First symbol is valid two cycles after start is sampled; then up to one symbol per cycle.
// symbol_out is held stable while out_ready is low; abort wins over a same-cycle handshake.
module symbol_emitter
    import symbols_pkg::*;
#(
    parameter int S_WIDTH   = 8,
    parameter int N_SYMBOLS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [$clog2(N_SYMBOLS)-1:0] cfg_addr,
    input  logic [S_WIDTH-1:0]           cfg_symbol,
    input  logic [CNT_W-1:0]             cfg_count,
    input  logic                         start,
    input  logic                         abort,
    output logic [S_WIDTH-1:0]           symbol_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic [TOTAL_W-1:0]           emitted_total
);

    localparam int            AW       = $clog2(N_SYMBOLS);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_SYMBOLS - 1);

    emit_state_t        state;
    logic [AW-1:0]      idx;
    logic [CNT_W-1:0]   remaining;
    logic [S_WIDTH-1:0] tbl_symbol;
    logic [CNT_W-1:0]   tbl_count;
    logic               tbl_we;

    // The table is frozen for the whole run so the stream is a snapshot of it.
    assign tbl_we = cfg_we && (state == ST_IDLE);
    assign busy   = (state != ST_IDLE);

    symbol_table #(
        .S_WIDTH   (S_WIDTH),
        .N_SYMBOLS (N_SYMBOLS)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (tbl_we),
        .wr_addr   (cfg_addr),
        .wr_symbol (cfg_symbol),
        .wr_count  (cfg_count),
        .rd_addr   (idx),
        .rd_symbol (tbl_symbol),
        .rd_count  (tbl_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            remaining     <= '0;
            out_valid     <= 1'b0;
            symbol_out    <= '0;
            done          <= 1'b0;
            emitted_total <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx           <= '0;
                        emitted_total <= '0;
                        state         <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        remaining <= tbl_count;
                        if (tbl_count != '0) begin
                            out_valid  <= 1'b1;
                            symbol_out <= tbl_symbol;
                            state      <= ST_EMIT;
                        end else if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        out_valid  <= 1'b0;
                        symbol_out <= '0;
                        state      <= ST_IDLE;
                    end else if (out_ready) begin
                        emitted_total <= sat_inc(emitted_total);
                        remaining     <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            out_valid  <= 1'b0;
                            symbol_out <= '0;
                            if (idx == LAST_IDX) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                idx   <= idx + AW'(1);
                                state <= ST_SCAN;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_emitter.sv
// Randomised bench for symbol_emitter; the reference stream is rebuilt from a table model.
module tb_symbol_emitter;

    localparam int N  = 8;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [SW-1:0] cfg_symbol = '0;
    logic [7:0]    cfg_count = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] symbol_out;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [10:0]   emitted_total;

    int tests_run = 0;
    int tests_failed = 0;

    logic [SW-1:0] m_sym [N];
    logic [7:0]    m_cnt [N];
    logic [SW-1:0] obs [$];
    logic [SW-1:0] exp_q [$];
    int done_cnt, done_cyc, first_vld, stall_bad, zero_bad;
    bit timed_out;

    symbol_emitter #(.S_WIDTH(SW), .N_SYMBOLS(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_symbol    (cfg_symbol),
        .cfg_count     (cfg_count),
        .start         (start),
        .abort         (abort),
        .symbol_out    (symbol_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .emitted_total (emitted_total)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void clear_model();
        for (int i = 0; i < N; i++) begin
            m_sym[i] = '0;
            m_cnt[i] = '0;
        end
    endfunction

    // Expected stream: every entry repeated count times, entries in index order.
    function automatic void build_expected();
        exp_q.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < int'(m_cnt[i]); j++)
                exp_q.push_back(m_sym[i]);
    endfunction

    function automatic bit stream_eq();
        if (obs.size() != exp_q.size()) return 1'b0;
        foreach (obs[i]) if (obs[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic write_entry(input int a, input logic [SW-1:0] s, input logic [7:0] c);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_symbol = s; cfg_count = c;
        @(negedge clk);
        cfg_we = 1'b0;
        m_sym[a] = s;
        m_cnt[a] = c;
    endtask

    // Pulses start, then watches the stream until the block returns to idle.
    // mode 0: always ready, 1: ready on odd cycles, 2: random ready.
    // inj >= 0: drive start plus a table write at that cycle (block is busy then).
    task automatic run(input int mode, input int budget, input int inj);
        bit prev_stall;
        logic [SW-1:0] prev_sym;
        obs.delete();
        done_cnt = 0; done_cyc = -1; first_vld = -1; stall_bad = 0; zero_bad = 0;
        timed_out = 1'b1; prev_stall = 1'b0; prev_sym = '0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (prev_stall && (!out_valid || symbol_out !== prev_sym)) stall_bad++;
            if (!out_valid && symbol_out !== '0) zero_bad++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (out_valid && first_vld < 0) first_vld = c;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 2) == 1;
                default: out_ready = ($urandom_range(0, 9) < 6);
            endcase
            if (out_valid && out_ready) obs.push_back(symbol_out);
            prev_stall = out_valid && !out_ready;
            prev_sym   = symbol_out;
            if (c == inj) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0;
                cfg_symbol = 8'h5A; cfg_count = 8'd5;
            end else if (c == inj + 1) begin
                start = 1'b0; cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, out_valid, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got busy/valid/done=%b required 000", {busy, out_valid, done});
        end
        tests_run++;
        if (symbol_out !== '0 || emitted_total !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got symbol=%0h total=%0d required 0/0", symbol_out, emitted_total);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic basic_table();
        write_entry(0, 8'h41, 8'd2);
        write_entry(1, 8'h42, 8'd0);
        write_entry(2, 8'h43, 8'd1);
        for (int i = 3; i < N; i++) write_entry(i, 8'h00, 8'd0);
    endtask

    task automatic test_basic();
        basic_table();
        build_expected();
        run(0, 200, -1);
        tests_run++;
        if (!stream_eq() || timed_out) begin
            tests_failed++;
            $display("FAIL basic_stream: got %0d symbols (timeout=%0d) required A,A,C", obs.size(), timed_out);
        end
        tests_run++;
        if (done_cnt != 1 || emitted_total !== 11'd3) begin
            tests_failed++;
            $display("FAIL basic_done_total: got done=%0d total=%0d required 1/3", done_cnt, emitted_total);
        end
        tests_run++;
        if (first_vld != 2) begin
            tests_failed++;
            $display("FAIL basic_latency: got first valid cycle %0d required 2", first_vld);
        end
        tests_run++;
        if (zero_bad != 0) begin
            tests_failed++;
            $display("FAIL basic_idle_zero: got %0d nonzero symbol cycles required 0", zero_bad);
        end
    endtask

    task automatic test_stall();
        build_expected();
        run(1, 200, -1);
        tests_run++;
        if (!stream_eq() || timed_out) begin
            tests_failed++;
            $display("FAIL stall_stream: got %0d symbols (timeout=%0d) required A,A,C", obs.size(), timed_out);
        end
        tests_run++;
        if (stall_bad != 0) begin
            tests_failed++;
            $display("FAIL stall_stable: got %0d unstable stall cycles required 0", stall_bad);
        end
        tests_run++;
        if (done_cnt != 1 || emitted_total !== 11'd3) begin
            tests_failed++;
            $display("FAIL stall_done_total: got done=%0d total=%0d required 1/3", done_cnt, emitted_total);
        end
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < N; i++) write_entry(i, 8'($urandom), 8'd0);
        run(0, 200, -1);
        tests_run++;
        if (first_vld != -1) begin
            tests_failed++;
            $display("FAIL zero_no_valid: got valid at cycle %0d required none", first_vld);
        end
        tests_run++;
        if (done_cyc != N + 1 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL zero_done_cycle: got cycle %0d count %0d required %0d/1", done_cyc, done_cnt, N + 1);
        end
        tests_run++;
        if (emitted_total !== 11'd0) begin
            tests_failed++;
            $display("FAIL zero_total: got %0d required 0", emitted_total);
        end
    endtask

    task automatic test_abort();
        int hs;
        int dseen;
        bit reached;
        for (int i = 0; i < N - 1; i++) write_entry(i, 8'h00, 8'd0);
        write_entry(N - 1, 8'($urandom), 8'd255);
        hs = 0; dseen = 0; reached = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) dseen++;
            if (out_valid && out_ready) hs++;
            if (hs == 10) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (!reached || busy !== 1'b0 || out_valid !== 1'b0 || symbol_out !== '0) begin
            tests_failed++;
            $display("FAIL abort_idle: got reached=%0d busy=%b valid=%b sym=%0h required 1/0/0/0",
                     reached, busy, out_valid, symbol_out);
        end
        tests_run++;
        if (emitted_total !== 11'd10) begin
            tests_failed++;
            $display("FAIL abort_total: got %0d required 10", emitted_total);
        end
        repeat (5) begin
            if (done) dseen++;
            @(negedge clk);
        end
        tests_run++;
        if (dseen != 0 || emitted_total !== 11'd10) begin
            tests_failed++;
            $display("FAIL abort_no_done: got done=%0d total=%0d required 0/10", dseen, emitted_total);
        end
    endtask

    task automatic test_ignore_busy();
        basic_table();
        build_expected();
        run(0, 200, 2);
        tests_run++;
        if (!stream_eq() || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL busy_ignore_stream: got %0d symbols done=%0d required A,A,C/1", obs.size(), done_cnt);
        end
        repeat (3) @(negedge clk);
        run(0, 200, -1);
        tests_run++;
        if (!stream_eq() || emitted_total !== 11'd3) begin
            tests_failed++;
            $display("FAIL busy_ignore_table: got %0d symbols total=%0d required A,A,C/3", obs.size(), emitted_total);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++)
                write_entry(i, 8'($urandom),
                            ($urandom_range(0, 9) < 3) ? 8'd0 : 8'($urandom_range(1, 6)));
            build_expected();
            run(2, 2000, -1);
            tests_run++;
            if (!stream_eq() || timed_out) begin
                tests_failed++;
                $display("FAIL rand_stream[%0d]: got %0d symbols required %0d (timeout=%0d)",
                         it, obs.size(), exp_q.size(), timed_out);
            end
            tests_run++;
            if (done_cnt != 1 || emitted_total !== 11'(exp_q.size())) begin
                tests_failed++;
                $display("FAIL rand_done_total[%0d]: got done=%0d total=%0d required 1/%0d",
                         it, done_cnt, emitted_total, exp_q.size());
            end
            tests_run++;
            if (stall_bad != 0 || zero_bad != 0) begin
                tests_failed++;
                $display("FAIL rand_stable[%0d]: got stall_bad=%0d zero_bad=%0d required 0/0",
                         it, stall_bad, zero_bad);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        write_entry(0, 8'h77, 8'd5);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (!seen || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            symbol_out !== '0 || emitted_total !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got seen=%0d valid=%b busy=%b done=%b sym=%0h total=%0d required 1/0/0/0/0/0",
                     seen, out_valid, busy, done, symbol_out, emitted_total);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        run(0, 200, -1);
        tests_run++;
        if (first_vld != -1 || done_cyc != N + 1 || emitted_total !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_cleared: got first_vld=%0d done_cyc=%0d total=%0d required -1/%0d/0",
                     first_vld, done_cyc, emitted_total, N + 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_all_zero();
        test_abort();
        test_ignore_busy();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/symbol_emitter.md
SYMBOL_EMITTER -- requirements
Module: symbol_emitter

Interface
REQ-001 Parameter S_WIDTH, default 8, width of one symbol.
REQ-002 Parameter N_SYMBOLS, default 8, number of alphabet/count table entries (>=2).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_we  input  1  table write strobe.
REQ-006 cfg_addr  input  $clog2(N_SYMBOLS)  table entry index.
REQ-007 cfg_symbol  input  S_WIDTH  alphabet symbol for entry.
REQ-008 cfg_count  input  8  occurrence count for entry.
REQ-009 start  input  1  begin emitting the table as a symbol stream.
REQ-010 abort  input  1  terminate emission immediately.
REQ-011 symbol_out  output  S_WIDTH  emitted symbol.
REQ-012 out_valid  output  1  symbol_out holds a valid symbol.
REQ-013 out_ready  input  1  downstream accepts symbol_out.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 emitted_total  output  11  symbols emitted in the current/last run.

Function
REQ-017 Block SHALL be the stream producer matching the symbol counter: each entry i emits symbol[i] exactly count[i] times, entries in ascending index order.
REQ-018 FSM states SHALL be IDLE, SCAN, EMIT, DONE.
REQ-019 cfg_we SHALL write symbol/count of cfg_addr in IDLE only; writes in other states SHALL be ignored; writes with cfg_addr >= N_SYMBOLS SHALL be ignored.
REQ-020 start SHALL be sampled in IDLE only: idx<=0, emitted_total<=0, go SCAN; start while busy SHALL be ignored.
REQ-021 SCAN (one cycle): remaining<=count[idx]; nonzero -> EMIT; zero and idx<N_SYMBOLS-1 -> idx+1, stay SCAN; zero and idx=N_SYMBOLS-1 -> DONE.
REQ-022 EMIT: out_valid=1, symbol_out=symbol[idx]; handshake = out_valid && out_ready.
REQ-023 On handshake: emitted_total+1, remaining-1; remaining=1 and idx last -> DONE; remaining=1 otherwise -> idx+1, SCAN; else stay EMIT.
REQ-024 symbol_out/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 Back-to-back handshakes within one entry SHALL give one symbol per cycle.
REQ-026 Latency: start sampled at edge k with count[0]!=0 -> out_valid high in cycle after edge k+1.
REQ-027 DONE (one cycle): done=1, then IDLE; all-zero table SHALL still produce done after N_SYMBOLS SCAN cycles with no output.
REQ-028 abort in any busy state SHALL return to IDLE next edge, out_valid low, no done pulse, emitted_total retained; abort has priority over handshake in the same cycle.
REQ-029 Table contents SHALL persist across runs and aborts.
REQ-030 out_valid SHALL be 0 outside EMIT; symbol_out SHALL be 0 outside EMIT.
REQ-031 emitted_total SHALL not wrap (max 255*N_SYMBOLS fits 11 bits for default N_SYMBOLS).

Reset
REQ-032 rst_n low SHALL force IDLE, idx=0, remaining=0, out_valid=0, symbol_out=0, busy=0, done=0, emitted_total=0, all table entries symbol=0 count=0.
REQ-033 Reset mid-run SHALL drop the current symbol without completing the handshake.

Structure
REQ-034 State enum and count width (8) SHALL live in shared package symbols_pkg with the counter blocks.
REQ-035 Table storage SHALL be one sub-module, symbol_table (write port + indexed read port, async reset).

Verification
REQ-036 Table {0:'A'x2, 1:'B'x0, 2:'C'x1, rest 0}, out_ready=1, start -> stream A,A,C; done once; emitted_total=3.
REQ-037 Same table, out_ready toggled 1/0 each cycle -> same stream, symbol_out stable during stalls.
REQ-038 All counts 0, start -> no out_valid, done exactly N_SYMBOLS+1 cycles after start edge.
REQ-039 Entry 7 count 255, start, then abort after 10 handshakes -> IDLE next cycle, no done, emitted_total=10.
REQ-040 start asserted and cfg_we to entry 0 during EMIT -> both ignored; stream unchanged.
REQ-041 rst_n pulsed low during EMIT -> all outputs zero asynchronously; subsequent start emits nothing (table cleared).
